// File: rtl/neuron_seq_ctrl_if.sv
// Handshake and register-enable bundle between the layer scheduler, the
// neuron sequencing controller and the MAC datapath.
interface neuron_seq_ctrl_if #(
  parameter int IDX_W = 8
);
  logic             start;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] idx;
  logic             acc_clr;
  logic             acc_en;
  logic             bias_en;
  logic             out_en;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, in_valid,
    input  in_ready, idx, acc_clr, acc_en, bias_en, out_en, busy, done
  );

  modport slave (
    input  start, abort, in_valid,
    output in_ready, idx, acc_clr, acc_en, bias_en, out_en, busy, done
  );
endinterface

// File: rtl/neuron_seq_ctrl.sv
// Sequences one neuron evaluation: clear, accumulate N_INPUTS beats, add
// bias, capture the result and pulse done. Drives register enables only.
module neuron_seq_ctrl #(
  parameter int N_INPUTS = 4,
  parameter int IDX_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  neuron_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_BIAS,
    S_CAPTURE,
    S_DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;

  logic in_ready;
  logic beat;
  logic acc_clr;
  logic acc_en;
  logic bias_en;
  logic out_en;
  logic done;
  logic aborting;

  // abort only matters once an evaluation is running
  assign aborting = bus.abort && (state_q != S_IDLE);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    count_d  = count_q;
    in_ready = 1'b0;
    beat     = 1'b0;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    bias_en  = 1'b0;
    out_en   = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        acc_clr = 1'b1;
        count_d = '0;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = !bus.abort;
        beat     = bus.in_valid && in_ready;
        acc_en   = beat;
        if (beat) begin
          // the last beat parks count at zero instead of running past the end
          if (count_q == LAST_IDX) begin
            count_d = '0;
            state_d = S_BIAS;
          end else begin
            count_d = count_q + IDX_W'(1);
          end
        end
      end
      S_BIAS: begin
        bias_en = !bus.abort;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        out_en  = !bus.abort;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = !bus.abort;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase

    if (aborting) begin
      state_d = S_IDLE;
      count_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.idx      = count_q;
  assign bus.acc_clr  = acc_clr;
  assign bus.acc_en   = acc_en;
  assign bus.bias_en  = bias_en;
  assign bus.out_en   = out_en;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done;

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Scoreboard bench for neuron_seq_ctrl: stimulus queues the expected enable
// pulses with their cycle numbers, a negedge monitor pops and compares them.
module tb_neuron_seq_ctrl;

  localparam int N_INPUTS = 4;
  localparam int IDX_W    = 8;

  typedef enum int {OP_CLR, OP_ACC, OP_BIAS, OP_OUT, OP_DONE} op_e;

  typedef struct {
    op_e op;
    int  idx;
    int  cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_total;
  int   n_bad;
  exp_t exp_q[$];

  neuron_seq_ctrl_if #(.IDX_W(IDX_W)) bus ();

  neuron_seq_ctrl #(
    .N_INPUTS(N_INPUTS),
    .IDX_W   (IDX_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input op_e op, input int idx, input int c);
    exp_t e;
    e.op  = op;
    e.idx = idx;
    e.cyc = c;
    exp_q.push_back(e);
  endfunction

  // Full evaluation whose CLEAR cycle is base; stall cycles inserted before beat 2.
  function automatic void push_eval(input int base, input int stall);
    push(OP_CLR, 0, base);
    for (int i = 0; i < N_INPUTS; i++)
      push(OP_ACC, i, base + 1 + i + ((i >= 2) ? stall : 0));
    push(OP_BIAS, 0, base + N_INPUTS + 1 + stall);
    push(OP_OUT,  0, base + N_INPUTS + 2 + stall);
    push(OP_DONE, 0, base + N_INPUTS + 3 + stall);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    check(name, int'({bus.in_ready, bus.acc_clr, bus.acc_en, bus.bias_en,
                      bus.out_en, bus.busy, bus.done, bus.idx}), 0);
  endtask

  // Returns the cycle number of the CLEAR state that follows the start pulse.
  task automatic start_pulse(output int base);
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1;
    base = cyc;
    bus.start = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [4:0] act;
    op_e        op;
    exp_t       e;
    act = {bus.done, bus.out_en, bus.bias_en, bus.acc_en, bus.acc_clr};
    if (rst_n && act != 5'd0) begin
      check("onehot", int'($onehot(act)), 1);
      if (act[0])      op = OP_CLR;
      else if (act[1]) op = OP_ACC;
      else if (act[2]) op = OP_BIAS;
      else if (act[3]) op = OP_OUT;
      else             op = OP_DONE;
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_out: got op=%0d at cyc %0d, expected no output", op, cyc);
      end else begin
        e = exp_q.pop_front();
        check("op", int'(op), int'(e.op));
        check("op_cyc", cyc, e.cyc);
        if (e.op == OP_ACC) check("idx", int'(bus.idx), e.idx);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    cyc          = 0;
    n_total      = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b1;

    // 1. reset and idle, in_valid high must be ignored
    cycles(2);
    check_zero("reset_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      check_zero("idle");
    end
    // start together with abort in IDLE is dropped
    bus.start = 1'b1;
    bus.abort = 1'b1;
    cycles(1);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_dropped", int'(bus.busy), 0);
    cycles(1);
    check("start_abort_still_idle", int'(bus.busy), 0);

    // 2. nominal evaluation
    start_pulse(base);
    push_eval(base, 0);
    check("busy_clear", int'(bus.busy), 1);
    cycles(7);
    check("busy_done", int'(bus.busy), 1);
    cycles(1);
    check("busy_after", int'(bus.busy), 0);
    cycles(2);
    check("nominal_drained", exp_q.size(), 0);

    // 3. three-cycle stall between beats 1 and 2
    start_pulse(base);
    push_eval(base, 3);
    cycles(3);
    bus.in_valid = 1'b0;
    #1;
    check("stall_idx", int'(bus.idx), 2);
    check("stall_acc_en", int'(bus.acc_en), 0);
    check("stall_in_ready", int'(bus.in_ready), 1);
    cycles(3);
    bus.in_valid = 1'b1;
    cycles(6);
    check("stall_drained", exp_q.size(), 0);
    check("stall_busy_after", int'(bus.busy), 0);

    // 4. abort on the idx=2 beat, then a clean evaluation
    start_pulse(base);
    push(OP_CLR, 0, base);
    push(OP_ACC, 0, base + 1);
    push(OP_ACC, 1, base + 2);
    cycles(3);
    bus.abort = 1'b1;
    #1;
    check("abort_idx", int'(bus.idx), 2);
    check("abort_in_ready", int'(bus.in_ready), 0);
    check("abort_acc_en", int'(bus.acc_en), 0);
    cycles(1);
    bus.abort = 1'b0;
    check_zero("abort_idle");
    cycles(8);
    check("abort_drained", exp_q.size(), 0);
    start_pulse(base);
    push_eval(base, 0);
    cycles(9);
    check("post_abort_drained", exp_q.size(), 0);

    // 5. asynchronous reset in the middle of ACCUM
    start_pulse(base);
    push(OP_CLR, 0, base);
    push(OP_ACC, 0, base + 1);
    cycles(2);
    check("pre_rst_idx", int'(bus.idx), 1);
    check("pre_rst_acc_en", int'(bus.acc_en), 1);
    #1 rst_n = 1'b0;
    #1;
    check_zero("async_rst_now");
    cycles(1);
    rst_n = 1'b1;
    cycles(3);
    check_zero("post_rst_idle");
    check("rst_drained", exp_q.size(), 0);

    // 6. start held high: two evaluations one IDLE cycle apart
    @(posedge clk);
    #1 bus.start = 1'b1;
    cycles(1);
    base = cyc;
    push_eval(base, 0);
    push_eval(base + N_INPUTS + 5, 0);
    cycles(N_INPUTS + 5);
    bus.start = 1'b0;
    check("second_eval_busy", int'(bus.busy), 1);
    cycles(N_INPUTS + 5);
    check("continuous_drained", exp_q.size(), 0);
    check("continuous_idle", int'(bus.busy), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
